// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating stall counter.
module pipe_stage_skid #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != SKID);
    assign out_data  = main_d;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n        = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n   = FULL;
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_n   = SKID;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    state_n        = FULL;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Flushed entries are zeroed so a squashed payload never lingers on out_data.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_d <= '0;
            skid_d <= '0;
        end else begin
            if (load_main) begin
                main_d <= main_from_skid ? skid_d : in_data;
            end
            if (load_skid) begin
                skid_d <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (out_valid && !out_ready && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed pins.
module tb_pipe_stage_skid;

    localparam int W = 128;
    localparam int CW = 4;
`ifdef PIPE_STAGE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    int           m_cnt;
    bit           m_zero;

    pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int lit(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic expect_eq(input string name, input logic [W-1:0] got,
                             input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic compare_model();
        expect_eq("out_valid", W'(out_valid), W'(q.size() > 0));
        expect_eq("in_ready", W'(in_ready), W'(q.size() < 2));
        expect_eq("stall_cnt", W'(stall_cnt), W'(CNT_EN ? m_cnt : 0));
        if (q.size() > 0) begin
            expect_eq("out_data", out_data, q[0]);
        end else if (m_zero) begin
            expect_eq("out_data_zero", out_data, '0);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
    task automatic cyc(input bit r, input bit f, input bit iv,
                       input logic [W-1:0] id, input bit ordy);
        int pre;
        reset = r;
        flush = f;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt = 0;
            m_zero = 1'b1;
        end else begin
            pre = q.size();
            if (pre > 0 && !ordy && m_cnt < (1 << CW) - 1) m_cnt++;
            if (pre > 0 && ordy) void'(q.pop_front());
            if (f) begin
                q.delete();
                m_zero = 1'b1;
            end else if (iv && pre < 2) begin
                q.push_back(id);
                m_zero = 1'b0;
            end
        end
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        logic [W-1:0] rd;
        m_cnt = 0;
        m_zero = 1'b1;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        cyc(1, 0, 0, '0, 0);
        cyc(1, 0, 0, '0, 0);
        expect_eq("rst_out_valid", W'(out_valid), '0);
        expect_eq("rst_in_ready", W'(in_ready), W'(1));
        expect_eq("rst_out_data", out_data, '0);
        expect_eq("rst_stall_cnt", W'(stall_cnt), '0);

        cyc(0, 0, 1, W'(1), 1);
        expect_eq("stream1", out_data, W'(1));
        cyc(0, 0, 1, W'(2), 1);
        expect_eq("stream2", out_data, W'(2));
        cyc(0, 0, 1, W'(3), 1);
        expect_eq("stream3", out_data, W'(3));
        expect_eq("stream_ready", W'(in_ready), W'(1));
        cyc(0, 0, 0, '0, 1);
        expect_eq("stream_drained", W'(out_valid), '0);

        cyc(0, 0, 1, W'('hA), 0);
        expect_eq("bp_ready_full", W'(in_ready), W'(1));
        cyc(0, 0, 1, W'('hB), 0);
        expect_eq("bp_ready_skid", W'(in_ready), '0);
        expect_eq("bp_hold_a", out_data, W'('hA));
        expect_eq("bp_cnt1", W'(stall_cnt), W'(lit(1)));
        cyc(0, 0, 1, W'('hF), 0);
        cyc(0, 0, 1, W'('hF), 0);
        expect_eq("bp_cnt3", W'(stall_cnt), W'(lit(3)));
        cyc(0, 0, 0, '0, 1);
        expect_eq("bp_then_b", out_data, W'('hB));
        expect_eq("bp_ready_back", W'(in_ready), W'(1));
        cyc(0, 0, 0, '0, 1);
        expect_eq("bp_empty", W'(out_valid), '0);

        cyc(0, 0, 1, W'('hD), 0);
        cyc(0, 0, 1, W'('hE), 0);
        cyc(0, 1, 1, W'('hC), 0);
        expect_eq("flush_valid", W'(out_valid), '0);
        expect_eq("flush_data", out_data, '0);
        expect_eq("flush_ready", W'(in_ready), W'(1));
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);

        cyc(1, 0, 0, '0, 0);
        cyc(0, 0, 1, W'('h5A), 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, '0, 0);
        expect_eq("sat_cnt", W'(stall_cnt), W'(lit(15)));
        cyc(0, 1, 0, '0, 0);
        expect_eq("sat_flush_kept", W'(stall_cnt), W'(lit(15)));

        for (int i = 0; i < 10000; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush. It replaces fixed-field, write-enable-only stage registers such as the EX→MEM latch. Each stage boundary of the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB) is one instance, with all stage fields concatenated into one payload bus. Downstream stalls are absorbed without a combinational ready path from output to input, and flush squashes in-flight instructions on branch or exception.

## Interface
Parameters:
- WIDTH, 128, payload width in bits (for example Instr+ALU+RD2+PC = 4×32); must be ≥1.
- CNT_W, 16, width of the stall counter; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  squash every held entry at the next edge.
- in_valid  input  1  upstream offers in_data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  stage accepts in_data this cycle.
- out_valid  output  1  out_data is a live instruction.
- out_data  output  WIDTH  downstream payload.
- out_ready  input  1  downstream consumes out_data this cycle.
- stall_cnt  output  CNT_W  saturating count of stalled output cycles.

## Operation
- State: main_v/main_d (output entry) and skid_v/skid_d (overflow entry). This gives three states:
  - EMPTY: main_v=0, skid_v=0.
  - FULL: main_v=1, skid_v=0.
  - SKID: main_v=1, skid_v=1.
- Output decode:
  - out_valid = main_v.
  - out_data = main_d.
  - in_ready = !skid_v, decoded from a register only; there is no combinational path from out_ready.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transitions, when reset=0 and flush=0:
  - EMPTY, in_fire → FULL; main_d ← in_data.
  - EMPTY, no in_fire → EMPTY.
  - FULL, in_fire & out_fire → FULL; main_d ← in_data.
  - FULL, in_fire & !out_ready → SKID; skid_d ← in_data; main_d holds.
  - FULL, !in_fire & out_fire → EMPTY.
  - FULL, neither → FULL; main_d holds.
  - SKID, out_fire → FULL; main_d ← skid_d; skid_v ← 0.
  - SKID, !out_fire → SKID; both entries hold.
- Flush: at the next edge main_v, skid_v, main_d and skid_d all go to 0 (state EMPTY).
  - Flush overrides any simultaneous in_fire; that input is dropped.
  - A simultaneous out_fire is still a valid consumption by downstream.
- Reset has priority over flush and clears the same registers plus stall_cnt.
- Ordering: entries leave in arrival order. The skid entry never overtakes main. No payload is lost or duplicated without a flush.
- stall_cnt increments by 1 on each edge where out_valid & !out_ready, and saturates at 2^CNT_W−1. It is not cleared by flush.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, stall_cnt=0. Internal skid_d=0.
- Latency: data accepted in cycle N appears on out_data in cycle N+1 when the stage was EMPTY or FULL-with-out_fire.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Backpressure: when out_ready falls, exactly one further word is accepted (into skid). in_ready drops the cycle after.
- Recovery: in_ready returns high one cycle after the SKID-state out_fire.
- Reset or flush asserted mid-stall: SKID→EMPTY in one edge, and in_ready=1 the following cycle.
- All outputs are registered or decoded from registers only.

## Configuration
- Macro PIPE_STAGE_STALL_CNT_EN.
- Defined: stall_cnt is implemented as specified.
- Undefined: no counter flops are built and stall_cnt is tied to 0. Handshake behaviour is identical in both builds.

## Test plan
- Reset then stream, WIDTH=128: hold reset 2 cycles, then push 0x1,0x2,0x3 with out_ready=1. Requires in_ready=1 throughout, out_data=0x1,0x2,0x3 on cycles N+1..N+3, and out_valid=0 afterwards.
- Backpressure: push 0xA then 0xB with out_ready=0. Requires in_ready=0 from the cycle after 0xB is accepted, out_data=0xA held, and stall_cnt counting 1,2,3…. Then raise out_ready: requires 0xA then 0xB in order, and in_ready=1 again one cycle after 0xA leaves.
- Flush in SKID with in_valid=1 (payload 0xC): requires out_valid=0 and out_data=0 next cycle, and 0xC never appears at the output.
- Saturation, CNT_W=4, out_ready=0 with out_valid=1 for 20 cycles: requires stall_cnt to stop at 15. With the macro undefined, stall_cnt=0 throughout.
- Random valid/ready, 10k cycles, scoreboard check: requires output sequence equal to the accepted input sequence, no in_fire while skid_v=1, and out_valid never asserted without a preceding in_fire.
